// File: rtl/rail_rush_pkg.sv
// Shared types and geometry for the Rail Rush obstacle pool:
// obstacle kinds, collision zone limits and per-kind sprite dimensions.
package rail_rush_pkg;

  typedef enum logic [1:0] {
    OBS_BARRIER = 2'd0,
    OBS_WIRE    = 2'd1,
    OBS_TRAIN   = 2'd2,
    OBS_COIN    = 2'd3
  } obs_type_t;

  localparam logic [9:0]  ZONE_Y_MIN    = 10'd440;
  localparam logic [9:0]  ZONE_Y_MAX    = 10'd490;
  localparam logic [9:0]  DEACT_Y       = 10'd620;
  localparam logic [11:0] HAZARD_HALF_W = 12'd40;
  localparam logic [11:0] COIN_HALF_W   = 12'd12;

  function automatic logic [11:0] obs_height(input obs_type_t t);
    case (t)
      OBS_BARRIER: return 12'd30;
      OBS_WIRE:    return 12'd15;
      OBS_TRAIN:   return 12'd100;
      default:     return 12'd20;
    endcase
  endfunction

  function automatic logic [11:0] obs_half_width(input obs_type_t t);
    return (t == OBS_COIN) ? COIN_HALF_W : HAZARD_HALF_W;
  endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: position/kind registers, per-frame move, collision
// and dodge detection, and the pixel cover test used by the renderer.
module obstacle_slot
  import rail_rush_pkg::*;
#(
  parameter int NUM_LANES  = 3,
  parameter int LANE_W     = 2,
  parameter int LANE0_X    = 144,
  parameter int LANE_PITCH = 256,
  parameter int SPD_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_update,
  input  logic              i_spawn,
  input  logic [LANE_W-1:0] i_spawn_lane,
  input  obs_type_t         i_spawn_type,
  input  logic [SPD_W-1:0]  i_speed,
  input  logic [LANE_W-1:0] i_player_lane,
  input  logic              i_jump_clear,
  input  logic              i_slide_clear,
  input  logic [9:0]        i_row,
  input  logic [9:0]        i_col,
  output logic              o_active,
  output logic [9:0]        o_y,
  output logic [LANE_W-1:0] o_lane,
  output obs_type_t         o_type,
  output logic              o_hit,
  output logic              o_coin,
  output logic              o_dodge,
  output logic              o_cover
);

  logic              r_active;
  logic              r_checked;
  logic [9:0]        r_y;
  logic [LANE_W-1:0] r_lane;
  obs_type_t         r_type;

  logic [9:0]  w_y_next;
  logic        w_expired;
  logic        w_in_zone;
  logic        w_hazard;
  logic        w_hit;
  logic        w_coin;
  logic        w_dodge;
  logic [11:0] w_cx;
  logic [11:0] w_hw;
  logic [11:0] w_h;
  logic [11:0] w_y12;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_y_next  = r_y + 10'(i_speed);
    w_expired = (r_y >= DEACT_Y);
    w_hazard  = (r_type != OBS_COIN);
    w_in_zone = r_active && (r_y >= ZONE_Y_MIN) && (r_y <= ZONE_Y_MAX) &&
                (r_lane == i_player_lane);
    w_hit     = w_in_zone && w_hazard && !r_checked &&
                (((r_type == OBS_BARRIER) && !i_jump_clear) ||
                 ((r_type == OBS_WIRE) && !i_slide_clear) ||
                 (r_type == OBS_TRAIN));
    w_coin    = w_in_zone && (r_type == OBS_COIN);
    // A hazard that was hit this frame is marked instead of counting as dodged.
    w_dodge   = r_active && w_hazard && !r_checked && !w_hit &&
                (r_y <= ZONE_Y_MAX) && (w_y_next > ZONE_Y_MAX);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every slot
  // sees pre-update values of its neighbours within the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_checked <= 1'b0;
      r_y       <= '0;
      r_lane    <= '0;
      r_type    <= OBS_BARRIER;
    end else if (i_clear) begin
      r_active  <= 1'b0;
      r_checked <= 1'b0;
      r_y       <= '0;
    end else if (i_update) begin
      if (!r_active) begin
        if (i_spawn) begin
          r_active  <= 1'b1;
          r_checked <= 1'b0;
          r_y       <= '0;
          r_lane    <= i_spawn_lane;
          r_type    <= i_spawn_type;
        end
      end else if (w_expired || w_coin) begin
        r_active  <= 1'b0;
        r_checked <= 1'b0;
        r_y       <= '0;
      end else begin
        r_y <= w_y_next;
        if (w_hit) r_checked <= 1'b1;
      end
    end
  end

  // Extent is [cx-hw, cx+hw) x [y, y+h); compared as col+hw >= cx to avoid underflow.
  always_comb begin
    w_cx    = 12'(LANE0_X) + 12'(r_lane) * 12'(LANE_PITCH);
    w_hw    = obs_half_width(r_type);
    w_h     = obs_height(r_type);
    w_y12   = 12'(r_y);
    o_cover = r_active &&
              ((12'(i_col) + w_hw) >= w_cx) && (12'(i_col) < (w_cx + w_hw)) &&
              (12'(i_row) >= w_y12) && (12'(i_row) < (w_y12 + w_h));
  end

  assign o_active = r_active;
  assign o_y      = r_y;
  assign o_lane   = r_lane;
  assign o_type   = r_type;
  assign o_hit    = w_hit;
  assign o_coin   = w_coin;
  assign o_dodge  = w_dodge;

endmodule

// File: rtl/obstacle_pool.sv
// Rail Rush obstacle pool: NUM_SLOTS slots, lowest-free-slot spawner with
// speed-scaled interval and per-lane gap, registered event pulses and count.
module obstacle_pool
  import rail_rush_pkg::*;
#(
  parameter int NUM_SLOTS     = 8,
  parameter int NUM_LANES     = 3,
  parameter int LANE0_X       = 144,
  parameter int LANE_PITCH    = 256,
  parameter int SPD_W         = 4,
  parameter int SPAWN_INIT    = 60,
  parameter int BASE_INTERVAL = 40,
  parameter int MIN_INTERVAL  = 16,
  parameter int MIN_GAP       = 120
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_done,
  input  logic                           game_active,
  input  logic                           clear,
  input  logic [15:0]                    lfsr_val,
  input  logic [SPD_W-1:0]               speed,
  input  logic [$clog2(NUM_LANES)-1:0]   player_lane,
  input  logic                           jump_clear,
  input  logic                           slide_clear,
  input  logic [9:0]                     row,
  input  logic [9:0]                     col,
  output logic                           obstacle_pixel,
  output logic [1:0]                     obstacle_pixel_type,
  output logic                           hit,
  output logic                           coin_collected,
  output logic                           dodge,
  output logic [$clog2(NUM_SLOTS+1)-1:0] active_count
);

  localparam int LANE_W = $clog2(NUM_LANES);
  localparam int CNT_W  = $clog2(NUM_SLOTS + 1);

  logic                 w_update;
  logic [NUM_SLOTS-1:0] w_active;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [NUM_SLOTS-1:0] w_coin;
  logic [NUM_SLOTS-1:0] w_dodge;
  logic [NUM_SLOTS-1:0] w_cover;
  logic [NUM_SLOTS-1:0] w_free_sel;
  logic [9:0]           w_y    [NUM_SLOTS];
  logic [LANE_W-1:0]    w_lane [NUM_SLOTS];
  obs_type_t            w_type [NUM_SLOTS];

  logic [LANE_W-1:0] w_spawn_lane;
  obs_type_t         w_spawn_type;
  logic [7:0]        w_sum;
  logic [7:0]        w_twice_speed;
  logic [7:0]        w_diff;
  logic [7:0]        w_interval;
  logic              w_found;
  logic              w_gap_block;
  logic              w_spawn_now;
  logic [CNT_W-1:0]  w_count;
  logic              w_unused_lfsr;

  logic [7:0]       r_spawn_timer;
  logic             r_hit;
  logic             r_coin;
  logic             r_dodge;
  logic [CNT_W-1:0] r_active_count;

  assign w_update      = frame_done && game_active && !clear;
  assign w_unused_lfsr = ^lfsr_val[15:10];

  always_comb begin
    w_spawn_lane = (int'(lfsr_val[1:0]) >= NUM_LANES) ? LANE_W'(NUM_LANES / 2)
                                                      : LANE_W'(lfsr_val[1:0]);
    w_spawn_type  = obs_type_t'(lfsr_val[3:2]);
    w_sum         = 8'(BASE_INTERVAL) + {2'b00, lfsr_val[9:4]};
    w_twice_speed = 8'({speed, 1'b0});
    w_diff        = (w_sum > w_twice_speed) ? (w_sum - w_twice_speed) : 8'd0;
    w_interval    = (w_diff > 8'(MIN_INTERVAL)) ? w_diff : 8'(MIN_INTERVAL);
  end

  // Free slot, gap and count all look at pre-update slot state.
  always_comb begin
    w_free_sel  = '0;
    w_found     = 1'b0;
    w_gap_block = 1'b0;
    w_count     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!w_active[i] && !w_found) begin
        w_free_sel[i] = 1'b1;
        w_found       = 1'b1;
      end
      if (w_active[i] && (w_lane[i] == w_spawn_lane) && (w_y[i] < 10'(MIN_GAP)))
        w_gap_block = 1'b1;
      w_count = w_count + CNT_W'(w_active[i]);
    end
    w_spawn_now = (r_spawn_timer == 8'd0) && w_found && !w_gap_block;
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    obstacle_slot #(
      .NUM_LANES (NUM_LANES),
      .LANE_W    (LANE_W),
      .LANE0_X   (LANE0_X),
      .LANE_PITCH(LANE_PITCH),
      .SPD_W     (SPD_W)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .i_clear      (clear),
      .i_update     (w_update),
      .i_spawn      (w_free_sel[g] && w_spawn_now),
      .i_spawn_lane (w_spawn_lane),
      .i_spawn_type (w_spawn_type),
      .i_speed      (speed),
      .i_player_lane(player_lane),
      .i_jump_clear (jump_clear),
      .i_slide_clear(slide_clear),
      .i_row        (row),
      .i_col        (col),
      .o_active     (w_active[g]),
      .o_y          (w_y[g]),
      .o_lane       (w_lane[g]),
      .o_type       (w_type[g]),
      .o_hit        (w_hit[g]),
      .o_coin       (w_coin[g]),
      .o_dodge      (w_dodge[g]),
      .o_cover      (w_cover[g])
    );
  end

  // A blocked spawn leaves the timer at zero so it retries next frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_spawn_timer  <= 8'(SPAWN_INIT);
      r_hit          <= 1'b0;
      r_coin         <= 1'b0;
      r_dodge        <= 1'b0;
      r_active_count <= '0;
    end else if (clear) begin
      r_spawn_timer  <= 8'(SPAWN_INIT);
      r_hit          <= 1'b0;
      r_coin         <= 1'b0;
      r_dodge        <= 1'b0;
      r_active_count <= '0;
    end else begin
      if (w_update) begin
        if (r_spawn_timer != 8'd0) r_spawn_timer <= r_spawn_timer - 8'd1;
        else if (w_spawn_now)      r_spawn_timer <= w_interval;
      end
      r_hit          <= w_update && (|w_hit);
      r_coin         <= w_update && (|w_coin);
      r_dodge        <= w_update && (|w_dodge);
      r_active_count <= w_count;
    end
  end

  always_comb begin
    obstacle_pixel      = |w_cover;
    obstacle_pixel_type = 2'b00;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_cover[i]) obstacle_pixel_type = w_type[i];
    end
  end

  assign hit            = r_hit;
  assign coin_collected = r_coin;
  assign dodge          = r_dodge;
  assign active_count   = r_active_count;

endmodule

// File: tb/tb_obstacle_pool.sv
// Directed scenarios for obstacle_pool (4 slots); event pulses are checked by
// a scoreboard monitor, counts and pixels by direct probes.
module tb_obstacle_pool;
  import rail_rush_pkg::*;

  localparam int NUM_SLOTS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_done;
  logic        game_active;
  logic        clear;
  logic [15:0] lfsr_val;
  logic [3:0]  speed;
  logic [1:0]  player_lane;
  logic        jump_clear;
  logic        slide_clear;
  logic [9:0]  row;
  logic [9:0]  col;
  logic        obstacle_pixel;
  logic [1:0]  obstacle_pixel_type;
  logic        hit;
  logic        coin_collected;
  logic        dodge;
  logic [2:0]  active_count;

  obstacle_pool #(.NUM_SLOTS(NUM_SLOTS)) dut (
    .clock              (clock),
    .reset              (reset),
    .frame_done         (frame_done),
    .game_active        (game_active),
    .clear              (clear),
    .lfsr_val           (lfsr_val),
    .speed              (speed),
    .player_lane        (player_lane),
    .jump_clear         (jump_clear),
    .slide_clear        (slide_clear),
    .row                (row),
    .col                (col),
    .obstacle_pixel     (obstacle_pixel),
    .obstacle_pixel_type(obstacle_pixel_type),
    .hit                (hit),
    .coin_collected     (coin_collected),
    .dodge              (dodge),
    .active_count       (active_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic hit;
    logic coin;
    logic dodge;
    int   cyc;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Pulses must appear exactly on the cycle the stimulus predicted.
  initial begin
    ev_t e;
    forever begin
      @(negedge clock);
      if (hit || coin_collected || dodge) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {29'd0, hit, coin_collected, dodge}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_bits", {29'd0, hit, coin_collected, dodge}, {29'd0, e.hit, e.coin, e.dodge});
          check("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic frame(input logic eh = 1'b0, input logic ec = 1'b0, input logic ed = 1'b0);
    @(negedge clock);
    if (eh || ec || ed) sb.push_back('{eh, ec, ed, cyc + 1});
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic check_count(input int expected);
    @(negedge clock);
    check("active_count", {29'd0, active_count}, expected);
  endtask

  task automatic probe(input string name, input int r, input int c, input logic exp_pix, input int exp_type);
    row = 10'(r);
    col = 10'(c);
    #1;
    check(name, {31'd0, obstacle_pixel}, {31'd0, exp_pix});
    if (exp_pix) check({name, "_type"}, {30'd0, obstacle_pixel_type}, exp_type);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // From reset/clear the timer is 60: nothing after 60 updates, spawn on the 61st.
  task automatic run_to_spawn();
    frames(60);
    check_count(0);
    frame();
    check_count(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    frame_done  = 1'b0;
    game_active = 1'b1;
    clear       = 1'b0;
    lfsr_val    = 16'h0000;
    speed       = 4'd0;
    player_lane = 2'd0;
    jump_clear  = 1'b0;
    slide_clear = 1'b0;
    row         = '0;
    col         = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    check("reset_count", {29'd0, active_count}, 0);
    check("reset_pulses", {29'd0, hit, coin_collected, dodge}, 0);
    probe("reset_pixel", 0, 144, 1'b0, 0);

    // First spawn with lfsr=0: lane 0 barrier at y=0 in slot 0.
    run_to_spawn();
    probe("a_pix_centre", 0, 144, 1'b1, OBS_BARRIER);

    // Barrier in lane 1, speed 5, interval 93: hit when y reaches 440, once.
    do_clear();
    lfsr_val    = 16'h03F1;
    speed       = 4'd5;
    player_lane = 2'd1;
    jump_clear  = 1'b0;
    run_to_spawn();
    probe("b_pix_centre", 0, 400, 1'b1, OBS_BARRIER);
    probe("b_pix_left_in", 0, 360, 1'b1, OBS_BARRIER);
    probe("b_pix_left_out", 0, 359, 1'b0, 0);
    probe("b_pix_right_in", 0, 439, 1'b1, OBS_BARRIER);
    probe("b_pix_right_out", 0, 440, 1'b0, 0);
    probe("b_pix_bottom_in", 29, 400, 1'b1, OBS_BARRIER);
    probe("b_pix_bottom_out", 30, 400, 1'b0, 0);
    for (int j = 1; j <= 100; j++) frame(j == 89, 1'b0, 1'b0);
    check_count(2);

    // Same with the player airborne: no hit, dodge on the 490 -> 495 step.
    do_clear();
    jump_clear = 1'b1;
    run_to_spawn();
    for (int j = 1; j <= 100; j++) frame(1'b0, 1'b0, j == 99);
    check_count(2);

    // Clear together with the frame that would hit: no pulse, timer back to 60.
    do_clear();
    jump_clear = 1'b0;
    run_to_spawn();
    frames(88);
    @(negedge clock);
    clear      = 1'b1;
    frame_done = 1'b1;
    @(negedge clock);
    clear      = 1'b0;
    frame_done = 1'b0;
    check_count(0);
    probe("c_pix_after_clear", 440, 400, 1'b0, 0);
    run_to_spawn();

    // Coin in lane 1; the player moves into lane 1 when y=445.
    do_clear();
    lfsr_val    = 16'h03FD;
    player_lane = 2'd0;
    run_to_spawn();
    probe("coin_pix_centre", 0, 400, 1'b1, OBS_COIN);
    probe("coin_pix_left_in", 0, 388, 1'b1, OBS_COIN);
    probe("coin_pix_left_out", 0, 387, 1'b0, 0);
    probe("coin_pix_right_in", 0, 411, 1'b1, OBS_COIN);
    probe("coin_pix_right_out", 0, 412, 1'b0, 0);
    probe("coin_pix_bottom_in", 19, 400, 1'b1, OBS_COIN);
    probe("coin_pix_bottom_out", 20, 400, 1'b0, 0);
    frames(89);
    check_count(1);
    player_lane = 2'd1;
    frame(1'b0, 1'b1, 1'b0);
    check_count(0);
    probe("coin_pix_gone", 450, 400, 1'b0, 0);

    // Lane field 3 falls back to lane 1; interval floored at 16; then speed 1
    // so the second spawn waits until the first is at y=120.
    do_clear();
    lfsr_val    = 16'h0003;
    speed       = 4'd15;
    player_lane = 2'd0;
    run_to_spawn();
    speed = 4'd1;
    frames(120);
    check_count(1);
    probe("gap_pix_before", 0, 400, 1'b0, 0);
    frame();
    check_count(2);
    probe("gap_pix_after", 0, 400, 1'b1, OBS_BARRIER);

    // Fill all 4 slots with lane-0 coins, then watch the full-pool retry.
    do_clear();
    lfsr_val    = 16'h000C;
    speed       = 4'd5;
    player_lane = 2'd2;
    run_to_spawn();
    frames(93);
    check_count(4);
    frames(31);
    check_count(4);
    frame();
    check_count(3);
    probe("full_pix_freed", 0, 144, 1'b0, 0);
    frame();
    check_count(4);
    probe("full_pix_respawn", 0, 144, 1'b1, OBS_COIN);

    repeat (4) @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
